draw_trace_multi: RTL



---
 rtl/draw_trace_multi_if.sv | 14 +
 rtl/draw_trace_multi.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_trace_multi_if.sv
// VGA pixel-stream bundle: timing counters, sync/blank strobes and 12-bit rgb.
// The 'in' modport is used by consumers and the 'out' modport by producers.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_trace_multi.sv
// Oscilloscope overlay: ping-pong sample capture, border/grid/trace composition (TRACE_LINE_EN = connected lines).
// Latency: 2 pixel clocks, all timing fields delayed alike.
// Backpressure: s_ready low from the beat that fills the back bank until the vblank swap.
module draw_trace_multi #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 256,
    parameter int SAMPLE_W = 8,
    parameter int X0       = 100,
    parameter int Y0       = 400,
    parameter int GRID     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    vga_if.in                            in,
    vga_if.out                           out,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [CHANNELS*SAMPLE_W-1:0] s_data
);
    localparam int AW     = $clog2(DEPTH);
    localparam int DW     = CHANNELS * SAMPLE_W;
    localparam int HEIGHT = 1 << SAMPLE_W;
    localparam logic signed [11:0] X0_S     = 12'(X0);
    localparam logic signed [11:0] Y0_S     = 12'(Y0);
    localparam logic signed [11:0] DEPTH_S  = 12'(DEPTH);
    localparam logic signed [11:0] HEIGHT_S = 12'(HEIGHT);
    localparam logic signed [11:0] GMASK    = 12'(GRID - 1);

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } pix_t;

    function automatic logic [11:0] trace_color(input int c);
        case (c)
            0:       return 12'hff0;
            1:       return 12'h0ff;
            2:       return 12'hf0f;
            default: return 12'h0f0;
        endcase
    endfunction

    // ---------------- capture / swap control ----------------
    logic [AW-1:0] wptr_q, wptr_d;
    logic back_full_q, back_full_d;
    logic front_valid_q, front_valid_d;
    logic bank_sel_q, bank_sel_d;
    logic vblnk_prev_q;
    logic wr_en, swap;

    assign s_ready = !back_full_q;
    assign wr_en   = s_valid && !back_full_q;
    // back_full_q is sampled in the edge cycle itself, so a bank filled by a beat in that cycle waits a frame
    assign swap    = in.vblnk && !vblnk_prev_q && back_full_q;

    always_comb begin
        wptr_d        = wptr_q;
        back_full_d   = back_full_q;
        front_valid_d = front_valid_q;
        bank_sel_d    = bank_sel_q;
        if (wr_en) begin
            wptr_d = wptr_q + 1'b1;
            if (wptr_q == {AW{1'b1}})
                back_full_d = 1'b1;
        end
        if (swap) begin
            bank_sel_d    = !bank_sel_q;
            front_valid_d = 1'b1;
            back_full_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q        <= '0;
            back_full_q   <= 1'b0;
            front_valid_q <= 1'b0;
            bank_sel_q    <= 1'b0;
            vblnk_prev_q  <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            back_full_q   <= back_full_d;
            front_valid_q <= front_valid_d;
            bank_sel_q    <= bank_sel_d;
            vblnk_prev_q  <= in.vblnk;
        end
    end

    // ---------------- stage 0: window geometry ----------------
    logic signed [11:0] x_c, r_c;
    logic col_c, row_c, border_c, grid_c;
    logic [AW-1:0] rd_addr;
    pix_t pix_in;

    assign x_c      = $signed({1'b0, in.hcount}) - X0_S;
    assign r_c      = Y0_S - $signed({1'b0, in.vcount});
    assign col_c    = (x_c >= 12'sd0) && (x_c < DEPTH_S);
    assign row_c    = (r_c >= 12'sd0) && (r_c < HEIGHT_S);
    assign border_c = (((r_c == -12'sd1) || (r_c == HEIGHT_S)) && (x_c >= -12'sd1) && (x_c <= DEPTH_S)) ||
                      (((x_c == -12'sd1) || (x_c == DEPTH_S)) && (r_c >= -12'sd1) && (r_c <= HEIGHT_S));
    assign grid_c   = col_c && row_c && (((x_c & GMASK) == 12'sd0) || ((r_c & GMASK) == 12'sd0));
    assign rd_addr  = x_c[AW-1:0];

    always_comb begin
        pix_in.vcount = in.vcount;
        pix_in.vsync  = in.vsync;
        pix_in.vblnk  = in.vblnk;
        pix_in.hcount = in.hcount;
        pix_in.hsync  = in.hsync;
        pix_in.hblnk  = in.hblnk;
        pix_in.rgb    = in.rgb;
    end

    // ---------------- sample banks (no reset on storage) ----------------
    logic [DW-1:0] bank0 [DEPTH];
    logic [DW-1:0] bank1 [DEPTH];
    logic [DW-1:0] rd0_q, rd1_q;

    always_ff @(posedge clk) begin
        if (wr_en && bank_sel_q)
            bank0[wptr_q] <= s_data;
        if (wr_en && !bank_sel_q)
            bank1[wptr_q] <= s_data;
        rd0_q <= bank0[rd_addr];
        rd1_q <= bank1[rd_addr];
    end

    // ---------------- stage 1 registers ----------------
    pix_t s1_pix_q;
    logic signed [11:0] s1_r_q;
    logic s1_col_q, s1_border_q, s1_grid_q, s1_fv_q, s1_sel_q;
`ifdef TRACE_LINE_EN
    logic s1_x0_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_pix_q    <= '0;
            s1_r_q      <= '0;
            s1_col_q    <= 1'b0;
            s1_border_q <= 1'b0;
            s1_grid_q   <= 1'b0;
            s1_fv_q     <= 1'b0;
            s1_sel_q    <= 1'b0;
`ifdef TRACE_LINE_EN
            s1_x0_q     <= 1'b0;
`endif
        end else begin
            s1_pix_q    <= pix_in;
            s1_r_q      <= r_c;
            s1_col_q    <= col_c;
            s1_border_q <= border_c;
            s1_grid_q   <= grid_c;
            s1_fv_q     <= front_valid_q;
            s1_sel_q    <= bank_sel_q;
`ifdef TRACE_LINE_EN
            s1_x0_q     <= (x_c == 12'sd0);
`endif
        end
    end

    // ---------------- stage 2: trace compare and composition ----------------
    logic [DW-1:0] rd_dat;
    logic [SAMPLE_W-1:0] smp [CHANNELS];
    logic [CHANNELS-1:0] hit;
    logic [11:0] rgb_d;
    pix_t s2_pix_d, s2_pix_q;

    assign rd_dat = s1_sel_q ? rd1_q : rd0_q;

`ifdef TRACE_LINE_EN
    logic [SAMPLE_W-1:0] prev_q [CHANNELS];
    logic [SAMPLE_W-1:0] prev_eff [CHANNELS];
    logic [SAMPLE_W-1:0] lo [CHANNELS];
    logic [SAMPLE_W-1:0] hi [CHANNELS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++)
                prev_q[c] <= '0;
        end else if (s1_col_q) begin
            for (int c = 0; c < CHANNELS; c++)
                prev_q[c] <= smp[c];
        end
    end
`endif

    always_comb begin
        hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            smp[c] = rd_dat[c*SAMPLE_W +: SAMPLE_W];
`ifdef TRACE_LINE_EN
            // the leftmost column has no neighbour, so it degenerates to a dot
            prev_eff[c] = s1_x0_q ? smp[c] : prev_q[c];
            lo[c]       = (prev_eff[c] < smp[c]) ? prev_eff[c] : smp[c];
            hi[c]       = (prev_eff[c] < smp[c]) ? smp[c] : prev_eff[c];
            hit[c]      = (s1_r_q >= $signed(12'(lo[c]))) && (s1_r_q <= $signed(12'(hi[c])));
`else
            hit[c]      = (s1_r_q == $signed(12'(smp[c])));
`endif
        end
    end

    always_comb begin
        rgb_d = s1_pix_q.rgb;
        if (s1_grid_q)
            rgb_d = 12'h444;
        if (s1_border_q)
            rgb_d = 12'hfa0;
        // walk downward so the lowest-index channel wins
        if (s1_fv_q && s1_col_q) begin
            for (int c = CHANNELS - 1; c >= 0; c--)
                if (hit[c])
                    rgb_d = trace_color(c);
        end
        s2_pix_d     = s1_pix_q;
        s2_pix_d.rgb = rgb_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s2_pix_q <= '0;
        else
            s2_pix_q <= s2_pix_d;
    end

    assign out.vcount = s2_pix_q.vcount;
    assign out.vsync  = s2_pix_q.vsync;
    assign out.vblnk  = s2_pix_q.vblnk;
    assign out.hcount = s2_pix_q.hcount;
    assign out.hsync  = s2_pix_q.hsync;
    assign out.hblnk  = s2_pix_q.hblnk;
    assign out.rgb    = s2_pix_q.rgb;
endmodule
